// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Definitions shared by the fetch stage and by decode:
//   - sequencing state encoding (RUN / HALT / FAULT)
//   - HALT_WORD, the SYSCALL encoding that stops fetch
//   - MIPS-style opcode/funct constants that decode uses for control-flow instrs
//   - is_word_aligned() helper, used for register-jump target checks
// ---------------------------------------------------------------------------
package fetch_pkg;

  // Sequencing states. HALT and FAULT are sticky and left only through reset.
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_HALT  = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  // SYSCALL encoding: opcode 0, funct 0x0C.
  localparam logic [31:0] HALT_WORD = 32'h0000_000C;

  // Opcodes of the control-flow instructions decode turns into fetch redirects.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  // R-type funct codes.
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;

  function automatic logic is_word_aligned(input logic [1:0] byte_lsbs);
    return (byte_lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// ---------------------------------------------------------------------------
// next_pc_sel
// Purely combinational next-PC selection for the fetch stage.
// Ports:
//   pc_plus4      in  S   sequential successor of the current PC
//   branch_taken  in  1   PC-relative branch requested
//   branch_offset in  16  signed word offset (imm16)
//   jump          in  1   pseudo-direct jump requested
//   jump_target   in  26  instruction index (instr[25:0])
//   jump_reg      in  1   register jump requested
//   jr_addr       in  S   register jump byte address
//   next_pc       out S   selected target: jump_reg > jump > branch > pc_plus4
//   jr_misalign   out 1   register jump requested to a non-word-aligned address
// ---------------------------------------------------------------------------
module next_pc_sel #(
  parameter int S = 32
) (
  input  logic [S-1:0] pc_plus4,
  input  logic         branch_taken,
  input  logic [15:0]  branch_offset,
  input  logic         jump,
  input  logic [25:0]  jump_target,
  input  logic         jump_reg,
  input  logic [S-1:0] jr_addr,
  output logic [S-1:0] next_pc,
  output logic         jr_misalign
);
  import fetch_pkg::*;

  logic [S-1:0] branch_pc;
  logic [S-1:0] jump_pc;

  // Word offset sign-extended and scaled to bytes; the add wraps mod 2^S.
  assign branch_pc = pc_plus4 + {{(S-18){branch_offset[15]}}, branch_offset, 2'b00};

  // Pseudo-direct: keep the 256 MB region of the delay-slot address.
  assign jump_pc = {pc_plus4[S-1:28], jump_target, 2'b00};

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (an unassigned path in always_comb infers a latch).
    next_pc = pc_plus4;
    if (jump_reg) begin
      next_pc = jr_addr;
    end else if (jump) begin
      next_pc = jump_pc;
    end else if (branch_taken) begin
      next_pc = branch_pc;
    end
  end

  assign jr_misalign = jump_reg && !is_word_aligned(jr_addr[1:0]);

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage: owns the PC, drives the word address into the
// asynchronous instruction memory and returns its data word, with RUN / HALT /
// FAULT sequencing plus run-cycle and retired-instruction counters.
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   stall                 hold the PC this cycle (downstream not ready)
//   branch_taken/_offset  PC-relative branch request and signed word offset
//   jump/jump_target      pseudo-direct jump request and instruction index
//   jump_reg/jr_addr      register jump request and byte address
//   imem_a / imem_d       word address out / same-cycle instruction word in
//   pc, pc_plus4          current PC and its link value
//   instr, instr_valid    fetched instruction (0 when not valid) and its valid
//   halted, fault         state is HALT / FAULT
//   cycle_cnt             cycles spent in RUN
//   retired_cnt           instructions accepted (valid and not stalled)
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int          S         = 32,
  parameter int          L         = 256,
  parameter logic [S-1:0] RESET_PC = '0,
  parameter logic [S-1:0] HALT_WORD = fetch_pkg::HALT_WORD,
  localparam int         ADDR_W    = $clog2(L)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [15:0]       branch_offset,
  input  logic              jump,
  input  logic [25:0]       jump_target,
  input  logic              jump_reg,
  input  logic [S-1:0]      jr_addr,
  output logic [ADDR_W-1:0] imem_a,
  input  logic [S-1:0]      imem_d,
  output logic [S-1:0]      pc,
  output logic [S-1:0]      pc_plus4,
  output logic [S-1:0]      instr,
  output logic              instr_valid,
  output logic              halted,
  output logic              fault,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       retired_cnt
);
  import fetch_pkg::*;

  logic [S-1:0] pc_q, pc_d;
  logic [1:0]   state_q, state_d;
  logic [31:0]  cycle_cnt_q, cycle_cnt_d;
  logic [31:0]  retired_cnt_q, retired_cnt_d;

  logic         running;
  logic         in_range;
  logic [S-1:0] next_pc;
  logic         jr_misalign;

  next_pc_sel #(.S(S)) u_next_pc_sel (
    .pc_plus4      (pc_plus4),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .jump_reg      (jump_reg),
    .jr_addr       (jr_addr),
    .next_pc       (next_pc),
    .jr_misalign   (jr_misalign)
  );

  assign running  = (state_q == ST_RUN);
  // Anything at or above 4*L bytes lies outside the instruction memory.
  assign in_range = (pc_q[S-1:ADDR_W+2] == '0);

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + S'(4);
  assign imem_a      = pc_q[ADDR_W+1:2];
  assign instr_valid = running && in_range;
  assign instr       = instr_valid ? imem_d : '0;
  assign halted      = (state_q == ST_HALT);
  assign fault       = (state_q == ST_FAULT);
  assign cycle_cnt   = cycle_cnt_q;
  assign retired_cnt = retired_cnt_q;

  always_comb begin
    pc_d          = pc_q;
    state_d       = state_q;
    cycle_cnt_d   = cycle_cnt_q;
    retired_cnt_d = retired_cnt_q;

    if (running) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
      if (!in_range) begin
        // A PC that walked off the end of memory faults and stays put.
        state_d = ST_FAULT;
      end else if (!stall) begin
        retired_cnt_d = retired_cnt_q + 32'd1;
        if (imem_d == HALT_WORD) begin
          // PC keeps pointing at the halting instruction.
          state_d = ST_HALT;
        end else if (jr_misalign) begin
          state_d = ST_FAULT;
        end else begin
          pc_d = next_pc;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      state_q       <= ST_RUN;
      cycle_cnt_q   <= '0;
      retired_cnt_q <= '0;
    end else begin
      pc_q          <= pc_d;
      state_q       <= state_d;
      cycle_cnt_q   <= cycle_cnt_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Scoreboard bench for fetch_unit. The driver applies one cycle of inputs,
// asks a behavioural model what the outputs must be during that cycle, pushes
// the expectation into a queue and advances the model. A separate monitor pops
// one expectation per cycle and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int          L      = 256;
  localparam logic [31:0] HALT_W = 32'h0000_000C;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        jump_reg;
  logic [31:0] jr_addr;
  logic [7:0]  imem_a;
  logic [31:0] imem_d;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic        instr_valid;
  logic        halted;
  logic        fault;
  logic [31:0] cycle_cnt;
  logic [31:0] retired_cnt;

  // Asynchronous instruction memory.
  logic [31:0] mem [0:L-1];
  assign imem_d = mem[imem_a];

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .jump_reg      (jump_reg),
    .jr_addr       (jr_addr),
    .imem_a        (imem_a),
    .imem_d        (imem_d),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .halted        (halted),
    .fault         (fault),
    .cycle_cnt     (cycle_cnt),
    .retired_cnt   (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic [31:0] cyc;
    logic [31:0] ret;
    logic [7:0]  a;
    logic        valid;
    logic        halted;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are settled 2 time units after the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("pc",          pc,                  mon_e.pc);
        check("pc_plus4",    pc_plus4,            mon_e.pc_plus4);
        check("imem_a",      32'(imem_a),         32'(mon_e.a));
        check("instr_valid", 32'(instr_valid),    32'(mon_e.valid));
        check("instr",       instr,               mon_e.instr);
        check("halted",      32'(halted),         32'(mon_e.halted));
        check("fault",       32'(fault),          32'(mon_e.fault));
        check("cycle_cnt",   cycle_cnt,           mon_e.cyc);
        check("retired_cnt", retired_cnt,         mon_e.ret);
      end
    end
  end

  // ---------------- reference model ----------------
  typedef enum {M_RUN, M_HALT, M_FAULT} mode_e;
  mode_e       m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_cyc;
  logic [31:0] m_ret;

  task automatic model_reset();
    m_mode = M_RUN;
    m_pc   = 32'h0;
    m_cyc  = 32'h0;
    m_ret  = 32'h0;
  endtask

  // One clock cycle: drive inputs, record expected outputs, advance the model.
  task automatic step(input logic rst_i, input logic stall_i,
                      input logic br_i, input logic [15:0] off_i,
                      input logic j_i, input logic [25:0] tgt_i,
                      input logic jr_i, input logic [31:0] jra_i);
    exp_t        e;
    logic        ok_addr;
    logic [31:0] word;
    logic [31:0] disp;
    @(negedge clk);
    #1;
    reset         = rst_i;
    stall         = stall_i;
    branch_taken  = br_i;
    branch_offset = off_i;
    jump          = j_i;
    jump_target   = tgt_i;
    jump_reg      = jr_i;
    jr_addr       = jra_i;

    if (rst_i) model_reset();

    ok_addr    = (m_pc < 4 * L);
    word       = mem[(m_pc / 4) % L];
    e.pc       = m_pc;
    e.pc_plus4 = m_pc + 32'd4;
    e.a        = 8'((m_pc / 4) % L);
    e.valid    = (m_mode == M_RUN) && ok_addr;
    e.instr    = e.valid ? word : 32'h0;
    e.halted   = (m_mode == M_HALT);
    e.fault    = (m_mode == M_FAULT);
    e.cyc      = m_cyc;
    e.ret      = m_ret;
    exp_q.push_back(e);

    if (!rst_i && m_mode == M_RUN) begin
      m_cyc = m_cyc + 32'd1;
      if (!ok_addr) begin
        m_mode = M_FAULT;
      end else if (!stall_i) begin
        m_ret = m_ret + 32'd1;
        if (word == HALT_W) begin
          m_mode = M_HALT;
        end else if (jr_i) begin
          if (jra_i % 4 != 0) m_mode = M_FAULT;
          else m_pc = jra_i;
        end else if (j_i) begin
          m_pc = ((m_pc + 32'd4) & 32'hF000_0000) + 32'(tgt_i) * 32'd4;
        end else if (br_i) begin
          disp = 32'(int'($signed(off_i)) * 4);
          m_pc = m_pc + 32'd4 + disp;
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic plain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
  endtask

  task automatic rnd_step(input logic allow_reset);
    logic        r_rst;
    logic [15:0] r_off;
    logic [31:0] r_jra;
    r_rst = allow_reset && ($urandom_range(0, 99) < 2);
    r_off = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 40)) - 16'd20
                                        : 16'($urandom);
    r_jra = ($urandom_range(0, 7) == 0) ? $urandom
                                        : 32'($urandom_range(0, 300)) * 32'd4;
    step(r_rst, $urandom_range(0, 3) == 0,
         $urandom_range(0, 7) == 0, r_off,
         $urandom_range(0, 9) == 0, 26'($urandom_range(0, 300)),
         $urandom_range(0, 15) == 0, r_jra);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] w;
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_offset = '0;
    jump = 1'b0; jump_target = '0; jump_reg = 1'b0; jr_addr = '0;
    for (int i = 0; i < L; i++) begin
      w = $urandom;
      if (w == HALT_W) w = 32'h0;
      mem[i] = w;
    end
    model_reset();

    // Reset, then sequential fetch 0,4,8,C and on to 0x10.
    do_reset();
    do_reset();
    plain(4);
    // At 0x10: branch back by 2 words -> 0x0C.
    step(1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0, 26'h0, 1'b0, 32'h0);
    plain(1);
    // At 0x10 again: branch +3 words -> 0x20.
    step(1'b0, 1'b0, 1'b1, 16'h0003, 1'b0, 26'h0, 1'b0, 32'h0);
    // All three redirects together: register jump wins -> 0x40.
    step(1'b0, 1'b0, 1'b1, 16'h0007, 1'b1, 26'h5, 1'b1, 32'h40);
    // Misaligned register jump -> FAULT, PC held, sticky under random inputs.
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h42);
    for (int i = 0; i < 4; i++) rnd_step(1'b0);
    do_reset();
    plain(2);

    // HALT instruction at 0x08 freezes PC and counters.
    mem[2] = HALT_W;
    do_reset();
    plain(5);
    for (int i = 0; i < 4; i++) rnd_step(1'b0);
    mem[2] = 32'h1234_5678;
    do_reset();

    // Stall held 3 cycles with a jump asserted: PC holds, cycle_cnt advances.
    plain(1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 26'h20, 1'b0, 32'h0);
    plain(2);

    // Sequential walk off the end of memory: 0x3FC valid, 0x400 faults.
    do_reset();
    plain(L + 3);

    // Randomised phase with a few halt words planted in memory.
    for (int i = 0; i < 3; i++) mem[$urandom_range(8, L - 1)] = HALT_W;
    do_reset();
    for (int i = 0; i < 1500; i++) rnd_step(1'b1);

    // Asynchronous reset mid-run: visible before the next rising edge.
    plain(3);
    do_reset();
    plain(2);

    repeat (3) @(negedge clk);
    #5;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
